// File: rtl/cu_adc_decimator_mc.sv
// Multi-channel ADC decimator: per-channel pick or block mean over 2^rate samples.
// Optional: define CU_DEC_ROUND_EN for round-half-up averaging.
module cu_adc_decimator_mc #(
  parameter int DATA_W = 16,
  parameter int NCH    = 4,
  parameter int CH_W   = 2,
  parameter int ACC_W  = DATA_W + 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drdy,
  input  logic [DATA_W-1:0] datain,
  input  logic [CH_W-1:0]   din_ch,
  input  logic [2:0]        rate,
  input  logic              mode,
  output logic [DATA_W-1:0] dataout,
  output logic [CH_W-1:0]   dout_ch,
  output logic              data_rdy
);

  localparam int CNT_W = 7;
  localparam logic [CH_W:0] NCH_L = (CH_W+1)'(NCH);

  logic                    drdy_d;
  logic [2:0]              rate_q;
  logic                    mode_q;
  logic [CNT_W-1:0]        cnt [NCH];
  logic signed [ACC_W-1:0] acc [NCH];

  logic                    accept;
  logic                    ch_ok;
  logic                    cfg_chg;
  logic                    take;
  logic                    last;
  logic [7:0]              blk;
  logic [CNT_W-1:0]        term;
  logic [CNT_W-1:0]        cnt_sel;
  logic signed [ACC_W-1:0] acc_sel;
  logic signed [ACC_W-1:0] din_sx;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] sum_r;
  logic [DATA_W-1:0]       avg;
  logic [DATA_W-1:0]       res;

  assign accept  = drdy & ~drdy_d;
  assign ch_ok   = {1'b0, din_ch} < NCH_L;
  assign cfg_chg = (rate != rate_q) || (mode != mode_q);
  assign take    = accept & ch_ok & ~cfg_chg;

  // Terminal count of the current block: 2^rate_q - 1.
  assign blk  = 8'd1 << rate_q;
  assign term = CNT_W'(blk - 8'd1);

  // Select the addressed channel's counter and accumulator.
  always_comb begin
    cnt_sel = '0;
    acc_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (din_ch == CH_W'(i)) begin
        cnt_sel = cnt[i];
        acc_sel = acc[i];
      end
    end
  end

  assign last   = (cnt_sel == term);
  assign din_sx = {{(ACC_W-DATA_W){datain[DATA_W-1]}}, datain};
  assign sum    = acc_sel + din_sx;

`ifdef CU_DEC_ROUND_EN
  // Half an LSB of the result, so the shift rounds half up.
  always_comb begin
    rnd = '0;
    if (rate_q != 3'd0) rnd = ACC_W'(1) <<< (rate_q - 3'd1);
  end
`else
  assign rnd = '0;
`endif

  assign sum_r = sum + rnd;
  assign avg   = DATA_W'(sum_r >>> rate_q);
  assign res   = mode_q ? avg : datain;

  // Config tracking, per-channel accumulation and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drdy_d   <= 1'b0;
      rate_q   <= rate;
      mode_q   <= mode;
      dataout  <= '0;
      dout_ch  <= '0;
      data_rdy <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
        acc[i] <= '0;
      end
    end else begin
      drdy_d   <= drdy;
      data_rdy <= 1'b0;
      if (cfg_chg) begin
        rate_q <= rate;
        mode_q <= mode;
        for (int i = 0; i < NCH; i++) begin
          cnt[i] <= '0;
          acc[i] <= '0;
        end
      end else if (take) begin
        for (int i = 0; i < NCH; i++) begin
          if (din_ch == CH_W'(i)) begin
            if (last) begin
              cnt[i] <= '0;
              acc[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
              acc[i] <= sum;
            end
          end
        end
        if (last) begin
          dataout  <= res;
          dout_ch  <= din_ch;
          data_rdy <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/cu_adc_decimator_mc.md
Name: cu_adc_decimator_mc

Overview:
Multi-channel, parametrised successor to the single-channel ADC decimator in the logger acquisition path. Accepts one ADC sample per drdy strobe, tagged with a channel index, and keeps an independent decimation counter and accumulator per channel. Each channel emits one output per 2^rate accepted samples, as either the last sample of the block (pick mode) or the block mean (average mode). Sits between the ADC capture unit and the logger FIFO/packetiser.

Parameters:
DATA_W, 16, sample width, two's complement signed
NCH, 4, number of channels (1..16)
CH_W, 2, channel index width; requires 2^CH_W >= NCH
ACC_W, DATA_W+7, accumulator width; holds 128 full-scale samples without overflow

Ports:
clk  in  1  system clock
rst  in  1  reset
drdy  in  1  sample strobe, synchronous to clk, may be held high for several cycles
datain  in  DATA_W  signed sample, valid while drdy high
din_ch  in  CH_W  channel tag of datain
rate  in  3  decimation factor 2^rate (0 -> 1 ... 7 -> 128)
mode  in  1  0 = pick (last sample), 1 = average
dataout  out  DATA_W  decimated signed sample
dout_ch  out  CH_W  channel of dataout
data_rdy  out  1  one-cycle output-valid pulse

Interface: one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst=1 at a clk edge): dataout=0, dout_ch=0, data_rdy=0, all per-channel counters and accumulators=0, drdy_d=0, rate_q=rate, mode_q=mode. rst overrides every other event.
- Accept edge: a clk edge with drdy=1 and drdy_d=0. drdy_d is drdy registered every cycle. Exactly one sample is taken per drdy high period, whatever its length.
- din_ch >= NCH at an accept edge: sample dropped, no state change.
- At an accept edge for channel c:
  - acc[c] <= acc[c] + sign_extend(datain).
  - cnt[c] <= cnt[c] + 1.
- Block complete when cnt[c] == 2^rate_q - 1 at the accept edge. At that same edge:
  - dataout <= datain (mode_q=0) or (acc[c]+datain) >>> rate_q, truncated to DATA_W (mode_q=1).
  - dout_ch <= c, data_rdy <= 1.
  - acc[c] <= 0, cnt[c] <= 0.
- Latency: data_rdy rises at the first clk edge at which drdy is seen high for the completing sample (1 clk). data_rdy is high for exactly one cycle. dataout and dout_ch hold their value until the next output.
- At most one output per accept edge, so no output arbitration is needed. Back-to-back accept edges are 2 clk apart at minimum.
- rate=0: every accepted sample is output unchanged in both modes.
- Average arithmetic:
  - Mean is always within DATA_W range, so no saturation is needed.
  - Shift is arithmetic, i.e. floor toward -inf, unless the optional feature is enabled.
- Config change: an edge where rate != rate_q or mode != mode_q:
  - rate_q/mode_q reload.
  - All cnt/acc clear.
  - Any sample accepted at that edge is dropped; no data_rdy.
  - drdy_d still updates.
- Partial blocks are never flushed. rst mid-block discards all partial sums.

Optional Feature:
CU_DEC_ROUND_EN defined: average mode adds 2^(rate_q-1) to the sum before the shift (round half up) when rate_q>0. Pick mode and rate_q=0 are unaffected.
Not defined: plain arithmetic shift (floor).

Test Plan:
1. Pick, rate=1, NCH=1, din_ch=0, datain 10,9,8,7 -> data_rdy pulses after the 2nd and 4th strobes, dataout 9 then 7, dout_ch=0.
2. Average, rate=1, samples 10,9 -> dataout 9 (floor); with CU_DEC_ROUND_EN -> 10. Samples -3,-4 -> -4 (floor); with CU_DEC_ROUND_EN -> -3.
3. Average, rate=7, constant 16'h7FFF for 128 strobes -> exactly one data_rdy, dataout 16'h7FFF (no overflow). Constant 16'h8000 -> 16'h8000.
4. Interleave channels 0,1,2,3 repeatedly, rate=2, average, ch c sample = 100*c+k (k=0..3) -> four outputs dout_ch 0..3, dataout 1,101,201,301 (floor of 1.5 -> 1).
5. drdy held high 10 clk per strobe, rate=0 -> one data_rdy per strobe. din_ch=5 with NCH=4 -> no output, no state change.
6. Change rate 2->3 after 3 samples on ch0 -> no output, counters cleared; 8 further samples -> single output. Assert rst after 1 of 2 samples -> all outputs 0; next 2 samples give a fresh block.
